// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared encodings between the GCD controller and datapath
package gcd_pkg;

    localparam logic [1:0] CMP_NONE = 2'd0;
    localparam logic [1:0] CMP_EQ   = 2'd1;
    localparam logic [1:0] CMP_A_GT = 2'd2;
    localparam logic [1:0] CMP_B_GT = 2'd3;

    localparam logic [1:0] EDIT_NONE = 2'd0;
    localparam logic [1:0] EDIT_A    = 2'd1;
    localparam logic [1:0] EDIT_B    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_HOLD  = 2'd3
    } dp_state_t;

endpackage

// File: rtl/gcd_compare.sv
// rtl/gcd_compare.sv - operand magnitude compare producing the controller compare code
module gcd_compare
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    input  logic             enable,
    output logic [1:0]       code
);

    always_comb begin
        code = CMP_NONE;
        if (enable) begin
            if (reg_a == reg_b) begin
                code = CMP_EQ;
            end else if (reg_a > reg_b) begin
                code = CMP_A_GT;
            end else begin
                code = CMP_B_GT;
            end
        end
    end

endmodule

// File: rtl/gcd_datapath.sv
// rtl/gcd_datapath.sv - operand/result datapath for the subtraction-based GCD engine
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 start,
    output logic [1:0]           compare,
    input  logic [1:0]           edit_num,
    input  logic                 get_res,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic [CNT_WIDTH-1:0] sub_count,
    output logic                 busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    dp_state_t      state;
    logic           rst_done;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;

    // rst_done keeps in_ready low during reset and for the first cycle after release
    assign in_ready = rst_done && (state == ST_IDLE);

    gcd_compare #(
        .WIDTH(WIDTH)
    ) u_compare (
        .reg_a  (reg_a),
        .reg_b  (reg_b),
        .enable (state == ST_RUN),
        .code   (compare)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            rst_done  <= 1'b0;
            reg_a     <= '0;
            reg_b     <= '0;
            result    <= '0;
            sub_count <= '0;
            start     <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (in_ready && in_valid) begin
                        reg_a     <= a_in;
                        reg_b     <= b_in;
                        sub_count <= '0;
                        // The controller never sees zero operands: it could not terminate on them
                        if (a_in == '0 || b_in == '0) begin
                            result    <= a_in | b_in;
                            out_valid <= 1'b1;
                            state     <= ST_HOLD;
                        end else begin
                            start <= 1'b1;
                            busy  <= 1'b1;
                            state <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    start <= 1'b0;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (get_res) begin
                        result    <= reg_a;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end else begin
                        case (edit_num)
                            EDIT_A: begin
                                reg_a <= reg_a - reg_b;
                                if (sub_count != CNT_MAX) begin
                                    sub_count <= sub_count + CNT_WIDTH'(1);
                                end
                            end
                            EDIT_B: begin
                                reg_b <= reg_b - reg_a;
                                if (sub_count != CNT_MAX) begin
                                    sub_count <= sub_count + CNT_WIDTH'(1);
                                end
                            end
                            EDIT_NONE: ;
                            default: ;
                        endcase
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
